spi_slave_sync: RTL
===================

Name: spi_slave_sync

Overview:
- SPI responder for the existing SPI master. Receives M-bit frames on MOSI and returns M-bit frames on MISO.
- Frames are delimited by LOAD (active-low select) and clocked by SCLK, both generated by the master.
- All SPI inputs are oversampled in the system clock domain. No logic is clocked by SCLK.
- Sits on the peripheral side of the link and hands parallel words to local logic via a valid/write handshake.

Parameters:
- M, 15, frame length in bits (2..16).
- RX_MSB_FIRST, 1: 1 = first MOSI bit lands in RX_MD[M-1]; 0 = first bit lands in RX_MD[0].

Ports:
- clk  in  1  system clock. Must be at least 8x the SCLK frequency.
- rst_n  in  1  reset: synchronous to clk, active-low.
- SCLK  in  1  serial clock from master; idles low.
- LOAD  in  1  frame select from master; high = idle, low = frame active.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master; always MSB first.
- TX_SD  in  M  word to send in the next frame.
- tx_wr  in  1  one-cycle strobe; captures TX_SD into the TX buffer.
- tx_pend  out  1  TX buffer holds a word not yet sent.
- RX_MD  out  M  last complete received word.
- rx_valid  out  1  one-cycle pulse when RX_MD updates.
- frame_err  out  1  one-cycle pulse when LOAD rises with bit count != M.
- tx_unf  out  1  one-cycle pulse when a frame starts with tx_pend=0.

Behaviour:
- **Reset** (rst_n=0 at a clk edge):
  - Synchronizers load idle values: SCLK=0, LOAD=1, MOSI=0.
  - MISO=0, RX_MD=0, tx_pend=0, rx_valid=0, frame_err=0, tx_unf=0.
  - Shift registers and bit counter cleared; FSM goes to IDLE.
  - Reset mid-frame abandons the frame. No rx_valid or frame_err is produced for it.
  - After reset, the slave ignores the link until LOAD is sampled high.
- **Input sync:** 2-FF synchronizer on each of SCLK, LOAD and MOSI. Edges are detected from the 2nd vs 3rd stage. Input-to-detected-edge latency is 3 clk.
- **FSM states:** IDLE, ACTIVE, WAIT_HI.
  - IDLE -> ACTIVE on LOAD fall.
    - If tx_pend=1: TX shift register <= TX buffer; tx_pend cleared the same cycle.
    - If tx_pend=0: TX shift register <= 0; tx_unf pulses.
    - In both cases, bit counter <= 0 and MISO immediately drives bit M-1 of the TX shift register.
  - ACTIVE, SCLK rise: sample the synchronized MOSI into the RX shift register and increment the bit counter (saturates at M+1).
    - RX_MSB_FIRST=1: shift left, new bit enters LSB.
    - RX_MSB_FIRST=0: shift right, new bit enters bit M-1.
  - ACTIVE, SCLK fall: TX shift left and MISO <= next bit. No shift on a fall before the first rise.
  - ACTIVE, LOAD rise:
    - Count == M: RX_MD <= RX shift register and rx_valid pulses the next cycle.
    - Otherwise: frame_err pulses and RX_MD is unchanged.
    - Then go to IDLE.
  - Simultaneous SCLK rise and LOAD rise in the same cycle: the rise is sampled first, then the frame closes.
  - WAIT_HI: entered only from reset; leaves to IDLE on LOAD high.
- **MISO timing:** MISO settles at most 4 clk after the synchronized SCLK fall. With clk >= 8x SCLK it is stable before the master samples on the next rise. MISO holds its last value while idle.
- **TX buffer:**
  - tx_wr loads TX_SD and sets tx_pend.
  - tx_wr while tx_pend=1 overwrites the buffer (last write wins).
  - tx_wr in the same cycle as frame start: the old buffer goes to the shifter, the new word is captured, and tx_pend stays 1.
- **RX_MD** holds until the next good frame. There is no back-pressure, so local logic must consume RX_MD within one frame time.

Test Plan:
1. **Good frame, MSB first.**
   - Setup: reset; tx_wr with TX_SD=15'h5A3C.
   - Stimulus: master sends 15'h1234 with M=15 and 15 SCLK pulses at clk/10.
   - Expected: RX_MD=15'h1234 with one rx_valid pulse; master receives 15'h5A3C; tx_pend goes 1->0 at LOAD fall.
2. **LSB-first receive.**
   - Setup: RX_MSB_FIRST=0.
   - Stimulus: master sends bit0 first of 15'h0001.
   - Expected: RX_MD=15'h0001.
3. **Short frame.**
   - Stimulus: LOAD rises after 7 SCLK pulses.
   - Expected: frame_err pulses once; RX_MD keeps its previous value; no rx_valid.
4. **Underrun.**
   - Stimulus: frame with no tx_wr since the last frame.
   - Expected: tx_unf pulses at LOAD fall; master receives 15'h0000; RX path still delivers.
5. **Reset mid-frame.**
   - Stimulus: assert rst_n=0 after 5 bits, release, finish the frame, then send a full frame of 15'h7FFF.
   - Expected: no rx_valid or frame_err for the broken frame; the next frame yields RX_MD=15'h7FFF.
6. **Write collision.**
   - Stimulus: tx_wr of 15'h0AAA, then tx_wr of 15'h0555 in the LOAD-fall cycle.
   - Expected: master receives 15'h0AAA; tx_pend remains 1 holding 15'h0555.

Source files
------------

// File: rtl/spi_slave_sync_if.sv
// ---------------------------------------------------------------------------
// spi_slave_sync_if
// Bundle of the SPI link and the local word handshake of spi_slave_sync.
//   SCLK, LOAD, MOSI : serial link driven by the SPI master (SCLK idles low,
//                      LOAD is an active-low frame select)
//   MISO             : serial reply to the master, MSB first
//   TX_SD, tx_wr     : local logic writes the next word to send
//   tx_pend          : a written word is still waiting for a frame
//   RX_MD, rx_valid  : last complete received word and its update pulse
//   frame_err        : frame closed with a wrong bit count
//   tx_unf           : frame started with nothing to send
// Modport "slave" is the responder side, "master" is everything around it.
// ---------------------------------------------------------------------------
interface spi_slave_sync_if #(
    parameter int M = 15
) ();
    logic         SCLK;
    logic         LOAD;
    logic         MOSI;
    logic         MISO;
    logic [M-1:0] TX_SD;
    logic         tx_wr;
    logic         tx_pend;
    logic [M-1:0] RX_MD;
    logic         rx_valid;
    logic         frame_err;
    logic         tx_unf;

    modport slave (
        input  SCLK, LOAD, MOSI, TX_SD, tx_wr,
        output MISO, tx_pend, RX_MD, rx_valid, frame_err, tx_unf
    );

    modport master (
        output SCLK, LOAD, MOSI, TX_SD, tx_wr,
        input  MISO, tx_pend, RX_MD, rx_valid, frame_err, tx_unf
    );
endinterface

// File: rtl/spi_slave_sync.sv
// ---------------------------------------------------------------------------
// spi_slave_sync
// SPI responder that oversamples SCLK/LOAD/MOSI in the clk domain (clk must
// be at least 8x SCLK). Receives M-bit frames on MOSI, returns M-bit frames
// on MISO (MSB first), and hands words to local logic.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous, active-low reset
//   bus    : spi_slave_sync_if.slave (link + TX buffer + RX word handshake)
// Parameters:
//   M            : frame length in bits (2..16)
//   RX_MSB_FIRST : 1 = first MOSI bit lands in RX_MD[M-1], 0 = in RX_MD[0]
// ---------------------------------------------------------------------------
module spi_slave_sync #(
    parameter int M            = 15,
    parameter bit RX_MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_sync_if.slave bus
);

    // Counter must reach M+1 so an overlong frame is distinguishable from M.
    localparam int             CW    = $clog2(M + 2);
    localparam logic [CW-1:0]  C_M   = CW'(M);
    localparam logic [CW-1:0]  C_MAX = CW'(M + 1);
    // Idle level of each synchronized input, indexed {SCLK, LOAD, MOSI}.
    localparam logic [2:0]     SYNC_IDLE = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_WAIT_HI
    } state_t;

    logic [2:0] w_in;
    logic [2:0] w_s2;
    logic [2:1] w_s3;

    assign w_in = {bus.SCLK, bus.LOAD, bus.MOSI};

    // Two flops per input for metastability; SCLK and LOAD get a third flop
    // purely for edge detection. MOSI needs no edge, so its chain stops at 2.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            localparam int DEPTH = (gi == 0) ? 2 : 3;
            logic [DEPTH-1:0] r_chain;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_chain <= {DEPTH{SYNC_IDLE[gi]}};
                end else begin
                    r_chain <= {r_chain[DEPTH-2:0], w_in[gi]};
                end
            end

            assign w_s2[gi] = r_chain[1];
            if (gi != 0) begin : g_edge
                assign w_s3[gi] = r_chain[2];
            end
        end
    endgenerate

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_load_rise;
    logic w_load_fall;
    logic w_load_hi;
    logic w_mosi;

    assign w_sclk_rise = w_s2[2] & ~w_s3[2];
    assign w_sclk_fall = ~w_s2[2] & w_s3[2];
    assign w_load_rise = w_s2[1] & ~w_s3[1];
    assign w_load_fall = ~w_s2[1] & w_s3[1];
    assign w_load_hi   = w_s2[1];
    assign w_mosi      = w_s2[0];

    state_t        r_state;
    logic [1:0]    r_settle;
    logic [CW-1:0] r_cnt;
    logic [M-1:0]  r_rx_shift;
    logic [M-1:0]  r_tx_shift;
    logic [M-1:0]  r_tx_buf;
    logic          r_tx_pend;
    logic [M-1:0]  r_rx_md;
    logic          r_rx_valid;
    logic          r_frame_err;
    logic          r_tx_unf;
    logic          r_miso;

    // RX shifter and bit counter with this cycle's SCLK rise already applied,
    // so a LOAD rise in the same cycle closes the frame on the updated values.
    logic [M-1:0]  w_rx_shifted;
    logic [CW-1:0] w_cnt_inc;
    logic [M-1:0]  w_rx_after;
    logic [CW-1:0] w_cnt_after;

    always_comb begin
        w_rx_shifted = RX_MSB_FIRST ? {r_rx_shift[M-2:0], w_mosi}
                                    : {w_mosi, r_rx_shift[M-1:1]};
        w_cnt_inc    = (r_cnt == C_MAX) ? r_cnt : r_cnt + CW'(1);
        w_rx_after   = w_sclk_rise ? w_rx_shifted : r_rx_shift;
        w_cnt_after  = w_sclk_rise ? w_cnt_inc : r_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_WAIT_HI;
            r_settle    <= 2'd0;
            r_cnt       <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_tx_buf    <= '0;
            r_tx_pend   <= 1'b0;
            r_rx_md     <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx_unf    <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx_unf    <= 1'b0;

            case (r_state)
                // The sync chains come out of reset holding idle values, not
                // real samples. Wait until they are flushed and then for a
                // genuine LOAD high, so a frame in flight at reset is ignored.
                S_WAIT_HI: begin
                    if (r_settle != 2'd3) begin
                        r_settle <= r_settle + 2'd1;
                    end else if (w_load_hi) begin
                        r_state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (w_load_fall) begin
                        r_state    <= S_ACTIVE;
                        r_cnt      <= '0;
                        r_rx_shift <= '0;
                        if (r_tx_pend) begin
                            r_tx_shift <= r_tx_buf;
                            r_miso     <= r_tx_buf[M-1];
                            r_tx_pend  <= 1'b0;
                        end else begin
                            r_tx_shift <= '0;
                            r_miso     <= 1'b0;
                            r_tx_unf   <= 1'b1;
                        end
                    end
                end

                S_ACTIVE: begin
                    r_rx_shift <= w_rx_after;
                    r_cnt      <= w_cnt_after;
                    if (w_load_rise) begin
                        if (w_cnt_after == C_M) begin
                            r_rx_md    <= w_rx_after;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else if (w_sclk_fall && (r_cnt != '0)) begin
                        // Count is zero only before the first rise; a stray
                        // fall there must not consume the first MISO bit.
                        r_tx_shift <= {r_tx_shift[M-2:0], 1'b0};
                        r_miso     <= r_tx_shift[M-2];
                    end
                end

                default: begin
                    r_state <= S_WAIT_HI;
                end
            endcase

            // Placed after the FSM so a write coinciding with frame start
            // keeps tx_pend set: the old word went to the shifter above.
            if (bus.tx_wr) begin
                r_tx_buf  <= bus.TX_SD;
                r_tx_pend <= 1'b1;
            end
        end
    end

    assign bus.MISO      = r_miso;
    assign bus.tx_pend   = r_tx_pend;
    assign bus.RX_MD     = r_rx_md;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.tx_unf    = r_tx_unf;

endmodule
